// File: rtl/pulpemu_spi_pkg.sv
// Shared constants, state encoding and byte-swap helper for the PULP SPI host.
package pulpemu_spi_pkg;

  localparam logic [1:0] SPI_STD     = 2'b00;
  localparam logic [1:0] SPI_QUAD_TX = 2'b01;
  localparam logic [1:0] SPI_QUAD_RX = 2'b10;

  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h0B;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_CMD,
    ST_ADDR,
    ST_WDATA,
    ST_DUMMY,
    ST_RDATA,
    ST_CS_HOLD,
    ST_RESP
  } spi_state_e;

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

endpackage

// File: rtl/pulpemu_spi_clkgen.sv
// SCLK half-period divider: produces the SCLK phase plus rise/fall/half-end pulses.
module pulpemu_spi_clkgen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic sclk_o,
  output logic rise_o,
  output logic fall_o,
  output logic half_o
);

  logic [7:0] cnt_q, cnt_d;
  logic       phase_q, phase_d;
  logic       last;

  assign last = (cnt_q == 8'(CLK_DIV - 1));

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (clr_i) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (en_i) begin
      if (last) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  // rise marks the first high cycle (sampling point); fall the last high cycle
  assign half_o = en_i & last;
  assign rise_o = en_i & phase_q & (cnt_q == '0);
  assign fall_o = half_o & phase_q;
  assign sclk_o = phase_q;

endmodule

// File: rtl/pulpemu_spi_host.sv
// Single-line SPI master issuing 0x02 write / 0x0B read frames to the PULP SPI slave.
module pulpemu_spi_host
  import pulpemu_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV           = 4,
  parameter int unsigned DUMMY_CYCLES      = 32,
  parameter int unsigned SWITCH_ENDIANNESS = 1
) (
  input  logic        zynq_clk,
  input  logic        zynq_rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        spi_clk_o,
  output logic        spi_csn_o,
  output logic [1:0]  spi_mode_o,
  output logic        spi_sdo0_o,
  input  logic        spi_sdi0_i,
  output logic        busy_o
);

  spi_state_e  state_q, state_d, seg_next;
  logic [15:0] bit_q, bit_d, seg_last;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [7:0]  cmd;
  logic        active, clk_clr, sclk, rise, fall, half;

  function automatic logic [31:0] endian(input logic [31:0] x);
    return (SWITCH_ENDIANNESS != 0) ? bswap32(x) : x;
  endfunction

  assign active  = (state_q != ST_IDLE) && (state_q != ST_RESP);
  // CS_SETUP is an extra low half; clearing at its end restarts the phase low for bit 0
  assign clk_clr = !active || ((state_q == ST_CS_SETUP) && half);
  assign cmd     = we_q ? CMD_WRITE : CMD_READ;

  pulpemu_spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk_i  (zynq_clk),
    .rst_i  (zynq_rst),
    .en_i   (active),
    .clr_i  (clk_clr),
    .sclk_o (sclk),
    .rise_o (rise),
    .fall_o (fall),
    .half_o (half)
  );

  always_comb begin
    seg_last = 16'd31;
    seg_next = ST_CS_HOLD;
    unique case (state_q)
      ST_CMD:   begin seg_last = 16'd7; seg_next = ST_ADDR; end
      ST_ADDR:  seg_next = we_q ? ST_WDATA : ((DUMMY_CYCLES == 0) ? ST_RDATA : ST_DUMMY);
      ST_DUMMY: begin seg_last = 16'(DUMMY_CYCLES - 1); seg_next = ST_RDATA; end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      ST_IDLE: if (req_valid_i) begin
        state_d = ST_CS_SETUP;
        we_d    = req_we_i;
        addr_d  = endian(req_addr_i);
        wdata_d = endian(req_wdata_i);
        rdata_d = '0;
        bit_d   = '0;
      end
      ST_CS_SETUP: if (half) state_d = ST_CMD;
      ST_CS_HOLD:  if (half) state_d = ST_RESP;
      ST_RESP:     if (resp_ready_i) state_d = ST_IDLE;
      default: if (fall) begin
        if (bit_q == seg_last) begin
          bit_d   = '0;
          state_d = seg_next;
        end else begin
          bit_d = bit_q + 16'd1;
        end
      end
    endcase
    if ((state_q == ST_RDATA) && rise) rdata_d = {rdata_q[30:0], spi_sdi0_i};
  end

  always_comb begin
    spi_sdo0_o = 1'b0;
    unique case (state_q)
      ST_CS_SETUP: spi_sdo0_o = cmd[7];
      ST_CMD:      spi_sdo0_o = cmd[3'd7 - bit_q[2:0]];
      ST_ADDR:     spi_sdo0_o = addr_q[5'd31 - bit_q[4:0]];
      ST_WDATA:    spi_sdo0_o = wdata_q[5'd31 - bit_q[4:0]];
      default: ;
    endcase
  end

  always_ff @(posedge zynq_clk) begin
    if (zynq_rst) begin
      state_q <= ST_IDLE;
      bit_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign spi_clk_o    = sclk && (state_q inside {ST_CMD, ST_ADDR, ST_WDATA, ST_DUMMY, ST_RDATA});
  assign spi_csn_o    = !active;
  assign spi_mode_o   = SPI_STD;
  assign req_ready_o  = (state_q == ST_IDLE);
  assign resp_valid_o = (state_q == ST_RESP);
  assign resp_rdata_o = (state_q == ST_RESP) ? endian(rdata_q) : '0;
  assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pulpemu_spi_host.sv
// Bench for pulpemu_spi_host: two instances (CLK_DIV=4/no swap, CLK_DIV=1/swap) against an SPI slave model.
module tb_pulpemu_spi_host;

  localparam int unsigned DUM = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        resp_valid[2];
  logic        resp_ready[2];
  logic [31:0] resp_rdata[2];
  logic        sclk      [2];
  logic        csn       [2];
  logic [1:0]  mode      [2];
  logic        sdo       [2];
  logic        miso      [2];
  logic        busy      [2];

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pulpemu_spi_host #(.CLK_DIV(4), .DUMMY_CYCLES(DUM), .SWITCH_ENDIANNESS(0)) dut0 (
    .zynq_clk(clk), .zynq_rst(rst),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_we_i(req_we[0]),
    .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
    .resp_valid_o(resp_valid[0]), .resp_ready_i(resp_ready[0]), .resp_rdata_o(resp_rdata[0]),
    .spi_clk_o(sclk[0]), .spi_csn_o(csn[0]), .spi_mode_o(mode[0]), .spi_sdo0_o(sdo[0]),
    .spi_sdi0_i(miso[0]), .busy_o(busy[0])
  );

  pulpemu_spi_host #(.CLK_DIV(1), .DUMMY_CYCLES(DUM), .SWITCH_ENDIANNESS(1)) dut1 (
    .zynq_clk(clk), .zynq_rst(rst),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_we_i(req_we[1]),
    .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
    .resp_valid_o(resp_valid[1]), .resp_ready_i(resp_ready[1]), .resp_rdata_o(resp_rdata[1]),
    .spi_clk_o(sclk[1]), .spi_csn_o(csn[1]), .spi_mode_o(mode[1]), .spi_sdo0_o(sdo[1]),
    .spi_sdi0_i(miso[1]), .busy_o(busy[1])
  );

  // ---------------- SPI slave model (mode 0, MSB first) ----------------
  logic        prev_sclk [2] = '{1'b0, 1'b0};
  logic        prev_csn  [2] = '{1'b1, 1'b1};
  int unsigned nrise     [2] = '{0, 0};
  logic [7:0]  s_cmd     [2];
  logic [31:0] s_addr    [2];
  logic [31:0] s_wdat    [2];
  logic [31:0] s_rword   [2];
  logic        s_done    [2];
  logic        s_sdo_bad [2];
  int unsigned s_first   [2];
  int unsigned s_last    [2];
  int unsigned s_pmin    [2];
  int unsigned s_pmax    [2];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!csn[k] && prev_csn[k]) begin
        nrise[k] <= 0; s_cmd[k] <= '0; s_addr[k] <= '0; s_wdat[k] <= '0;
        s_done[k] <= 1'b0; s_sdo_bad[k] <= 1'b0; s_pmin[k] <= 32'hFFFF; s_pmax[k] <= 0;
        miso[k] <= 1'b0;
      end else if (csn[k] === 1'b0) begin
        if (sclk[k] && !prev_sclk[k]) begin
          if (nrise[k] < 8)       s_cmd[k]  <= {s_cmd[k][6:0], sdo[k]};
          else if (nrise[k] < 40) s_addr[k] <= {s_addr[k][30:0], sdo[k]};
          else if (s_cmd[k] == 8'h02 && nrise[k] < 72) s_wdat[k] <= {s_wdat[k][30:0], sdo[k]};
          else if (s_cmd[k] == 8'h0B && sdo[k]) s_sdo_bad[k] <= 1'b1;
          if (nrise[k] == 0) s_first[k] <= cyc;
          else begin
            if (cyc - s_last[k] < s_pmin[k]) s_pmin[k] <= cyc - s_last[k];
            if (cyc - s_last[k] > s_pmax[k]) s_pmax[k] <= cyc - s_last[k];
          end
          s_last[k] <= cyc;
          nrise[k]  <= nrise[k] + 1;
        end
        if (!sclk[k] && prev_sclk[k]) begin
          if (s_cmd[k] == 8'h0B && nrise[k] >= 40 + DUM && nrise[k] < 72 + DUM)
            miso[k] <= s_rword[k][31 - (nrise[k] - 40 - DUM)];
          else
            miso[k] <= 1'b0;
        end
      end else if (prev_csn[k] === 1'b0) begin
        s_done[k] <= 1'b1;
      end
      prev_sclk[k] <= sclk[k];
      prev_csn[k]  <= csn[k];
    end
  end

  // ---------------- reference helpers ----------------
  function automatic logic [31:0] byterev(input logic [31:0] x);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = x[8*(3-b) +: 8];
    return r;
  endfunction

  function automatic int unsigned div_of(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  function automatic logic [31:0] wire_of(input int k, input logic [31:0] x);
    return (k == 1) ? byterev(x) : x;
  endfunction

  function automatic int unsigned lat_of(input int k, input logic we);
    int unsigned n;
    n = we ? 72 : 72 + DUM;
    return div_of(k) * (2 + 2 * n) + 1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_req(input int k, input logic we, input logic [31:0] a,
                           input logic [31:0] d, output int unsigned acc);
    logic got;
    got = 1'b0;
    req_we[k] = we; req_addr[k] = a; req_wdata[k] = d; req_valid[k] = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (req_ready[k]) begin got = 1'b1; break; end
      @(negedge clk);
    end
    chk("accept", 64'(got), 64'd1);
    acc = cyc;
    @(negedge clk);
    req_valid[k] = 1'b0;
    chk("cs_low_after_accept", {62'd0, csn[k], sclk[k]}, 64'd0);
  endtask

  task automatic wait_resp(input int k, input int unsigned acc, input int unsigned exp_lat,
                           input int hold, input logic [31:0] exp_rd, output int unsigned hs);
    logic got, bad, unstable;
    logic [31:0] held;
    got = 1'b0; bad = 1'b0; unstable = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (resp_valid[k]) begin got = 1'b1; break; end
      if (req_ready[k] || !busy[k] || mode[k] != 2'b00) bad = 1'b1;
      @(negedge clk);
    end
    chk("resp_seen", 64'(got), 64'd1);
    chk("latency", 64'(cyc - acc), 64'(exp_lat));
    chk("busy_flags", 64'(bad), 64'd0);
    held = resp_rdata[k];
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!resp_valid[k] || resp_rdata[k] !== held || req_ready[k] || !csn[k]) unstable = 1'b1;
    end
    chk("resp_hold", 64'(unstable), 64'd0);
    chk("rdata", 64'(resp_rdata[k]), 64'(exp_rd));
    resp_ready[k] = 1'b1;
    hs = cyc;
    @(negedge clk);
    resp_ready[k] = 1'b0;
    chk("resp_dropped", 64'(resp_valid[k]), 64'd0);
  endtask

  task automatic check_slave(input int k, input int unsigned acc, input logic we,
                             input logic [31:0] ea, input logic [31:0] ed);
    int unsigned per;
    per = 2 * div_of(k);
    chk("slave_done", 64'(s_done[k]), 64'd1);
    chk("wire_cmd", 64'(s_cmd[k]), we ? 64'h02 : 64'h0B);
    chk("wire_addr", 64'(s_addr[k]), 64'(ea));
    chk("bit_count", 64'(nrise[k]), we ? 64'd72 : 64'(72 + DUM));
    chk("first_rise", 64'(s_first[k] - acc), 64'(2 * div_of(k) + 1));
    chk("bit_period", {32'(s_pmin[k]), 32'(s_pmax[k])}, {32'(per), 32'(per)});
    if (we) chk("wire_wdata", 64'(s_wdat[k]), 64'(ed));
    else    chk("sdo_idle_in_read", 64'(s_sdo_bad[k]), 64'd0);
  endtask

  task automatic txn(input int k, input logic we, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] rword, input int hold);
    int unsigned acc, hs;
    s_rword[k] = wire_of(k, rword);
    start_req(k, we, a, d, acc);
    wait_resp(k, acc, lat_of(k, we), hold, we ? 32'd0 : rword, hs);
    check_slave(k, acc, we, wire_of(k, a), wire_of(k, d));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int unsigned acc, acc2, hs;
    logic seen, reached;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = '0; req_wdata[k] = '0;
      resp_ready[k] = 1'b0; s_rword[k] = '0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++)
      chk("reset_state",
          {22'd0, csn[k], sclk[k], sdo[k], mode[k], req_ready[k], resp_valid[k], busy[k], resp_rdata[k]},
          {22'd0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 32'd0});
    rst = 1'b0;
    @(negedge clk);

    // plain write and read, CLK_DIV=4, no swap
    txn(0, 1'b1, 32'h1C00_0000, 32'hDEAD_BEEF, 32'h0, 0);
    txn(0, 1'b0, 32'h1A10_0000, 32'h0, 32'h1234_5678, 0);

    // byte swap on the wire, CLK_DIV=1
    s_rword[1] = '0;
    start_req(1, 1'b1, 32'h0000_0010, 32'h1122_3344, acc);
    wait_resp(1, acc, 147, 0, 32'h0, hs);
    check_slave(1, acc, 1'b1, 32'h1000_0000, 32'h4433_2211);

    // request while busy, response back-pressured for 10 cycles
    start_req(0, 1'b1, 32'h1C00_0040, 32'hCAFE_F00D, acc);
    req_we[0] = 1'b0; req_addr[0] = 32'h1C00_0080; req_wdata[0] = '0; req_valid[0] = 1'b1;
    s_rword[0] = 32'hA5C3_0F96;
    wait_resp(0, acc, 585, 10, 32'h0, hs);
    check_slave(0, acc, 1'b1, 32'h1C00_0040, 32'hCAFE_F00D);
    start_req(0, 1'b0, 32'h1C00_0080, 32'h0, acc2);
    chk("accept_after_resp", 64'(acc2 - hs), 64'd1);
    wait_resp(0, acc2, 841, 0, 32'hA5C3_0F96, hs);
    check_slave(0, acc2, 1'b0, 32'h1C00_0080, 32'h0);

    // reset in the middle of the address phase
    start_req(0, 1'b1, 32'h1C00_1000, 32'h0BAD_0BAD, acc);
    reached = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (nrise[0] >= 20) begin reached = 1'b1; break; end
      @(negedge clk);
    end
    chk("reached_addr_phase", 64'(reached), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_state", {58'd0, csn[0], sclk[0], sdo[0], resp_valid[0], busy[0], req_ready[0]},
        {58'd0, 6'b100001});
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (resp_valid[0] || !csn[0]) seen = 1'b1;
    end
    chk("no_resp_after_abort", 64'(seen), 64'd0);
    txn(0, 1'b1, 32'h1C00_2000, 32'h7654_3210, 32'h0, 0);

    // back-to-back write then read at CLK_DIV=1
    txn(1, 1'b1, 32'h1C00_0100, 32'h0102_0304, 32'h0, 0);
    txn(1, 1'b0, 32'h1C00_0100, 32'h0, 32'h0102_0304, 0);

    // random traffic on both instances
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 6; i++)
        txn(k, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, int'($urandom_range(0, 3)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pulpemu_spi_host.md
PULPEMU_SPI_HOST -- requirements
Module: pulpemu_spi_host

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning zynq_clk cycles per SCLK half-period (legal range 1..255).
REQ-002 SHALL have parameter DUMMY_CYCLES, default 32, meaning SCLK cycles inserted between address and read data.
REQ-003 SHALL have parameter SWITCH_ENDIANNESS, default 1, meaning a byte swap on address and data at the request/response side.
REQ-004 SHALL have ports zynq_clk, in, 1, sole clock; zynq_rst, in, 1, reset, synchronous, active-high.
REQ-005 SHALL have ports req_valid_i in 1, req_ready_o out 1, req_we_i in 1 (1=write), req_addr_i in 32, req_wdata_i in 32.
REQ-006 SHALL have ports resp_valid_o out 1, resp_ready_i in 1, resp_rdata_o out 32.
REQ-007 SHALL have ports spi_clk_o out 1, spi_csn_o out 1, spi_mode_o out 2, spi_sdo0_o out 1 (MOSI), spi_sdi0_i in 1 (MISO), busy_o out 1.

Function
REQ-008 SHALL act as the SPI master driving the PULP SPI slave in standard single-line mode: spi_mode_o constantly 2'b00, SCLK idle low, MSB first.
REQ-009 SHALL accept a request when req_valid_i && req_ready_o; req_ready_o high only in IDLE with no response pending; the accepted addr/wdata/we are latched.
REQ-010 SHALL implement states IDLE -> CS_SETUP -> CMD(8 bits) -> ADDR(32) -> WDATA(32) -> CS_HOLD -> RESP for writes, and CMD -> ADDR -> DUMMY(DUMMY_CYCLES) -> RDATA(32) -> CS_HOLD -> RESP for reads.
REQ-011 SHALL send command byte 0x02 for writes and 0x0B for reads.
REQ-012 SHALL drive spi_csn_o low in the cycle after acceptance and hold it low for CLK_DIV cycles (CS_SETUP) before the first SCLK rising edge.
REQ-013 Each bit SHALL last 2*CLK_DIV cycles: SDO changes together with the SCLK falling edge (first bit at CS_SETUP), SCLK is high for the second CLK_DIV cycles, and spi_sdi0_i is sampled on the rising-edge cycle.
REQ-014 SHALL drive spi_sdo0_o 0 during DUMMY and RDATA, and when CS is high.
REQ-015 After the last falling edge SHALL hold CS low CLK_DIV cycles (CS_HOLD), then raise spi_csn_o and enter RESP.
REQ-016 SHALL assert resp_valid_o in RESP and hold it, with resp_rdata_o stable, until resp_ready_i, then return to IDLE; for writes resp_rdata_o is 0.
REQ-017 Acceptance-to-resp_valid_o latency SHALL be CLK_DIV*(2+2*N)+1 cycles, where N=72 for a write and N=72+DUMMY_CYCLES for a read.
REQ-018 With SWITCH_ENDIANNESS=1, SHALL byte-reverse req_addr_i and req_wdata_i before shifting and byte-reverse the received word before resp_rdata_o; with 0, SHALL pass them unchanged.
REQ-019 busy_o SHALL be high in every state except IDLE.
REQ-020 A request arriving while busy SHALL remain unaccepted (req_ready_o=0) with no loss; req_valid_i and resp_ready_i high together in RESP SHALL complete the response only, and the next request is accepted no earlier than the following IDLE cycle.
REQ-021 Bit counters SHALL wrap to 0 on each state transition; the divider counter SHALL reload exactly at CLK_DIV-1 with no drift across states.

Reset
REQ-022 When zynq_rst is high at a zynq_clk edge, SHALL enter IDLE with outputs spi_csn_o=1, spi_clk_o=0, spi_sdo0_o=0, spi_mode_o=0, req_ready_o=1, resp_valid_o=0, resp_rdata_o=0, busy_o=0.
REQ-023 Reset mid-transfer SHALL abort immediately (CS high the next cycle) and issue no response.

Structure
REQ-024 Package pulpemu_spi_pkg SHALL hold the SPI_STD/QUAD_TX/QUAD_RX mode constants, the command codes 0x02/0x0B, and the state enum.
REQ-025 SHALL contain one sub-module, pulpemu_spi_clkgen, which generates the rise/fall tick pulses from CLK_DIV, with enable and a synchronous clear.

Verification
REQ-026 Write addr=0x1C000000, wdata=0xDEADBEEF, SWITCH_ENDIANNESS=0, CLK_DIV=4 -> slave model captures 0x02, 0x1C000000, 0xDEADBEEF; resp_valid_o after 585 cycles.
REQ-027 Read addr=0x1A100000, slave returns 0x12345678 after 32 dummy cycles -> resp_rdata_o=0x12345678 after 841 cycles.
REQ-028 SWITCH_ENDIANNESS=1, write addr=0x00000010, wdata=0x11223344 -> wire shows address 0x10000000, data 0x44332211.
REQ-029 Second req_valid_i during busy and resp_ready_i held low 10 cycles -> req_ready_o=0 throughout, resp_valid_o held with stable data, then second request accepted and completed correctly.
REQ-030 zynq_rst pulsed in the middle of ADDR -> next cycle spi_csn_o=1, spi_clk_o=0, no resp_valid_o, and a subsequent write completes normally.
REQ-031 CLK_DIV=1, back-to-back write then read -> bit period of 2 cycles and correct data on both transfers.
